// File: rtl/poly_mod_pkg.sv
// Shared types and sizing for the modular squaring datapath
// and the iteration sequencer that drives it.
package poly_mod_pkg;

    localparam int WORD_BITS   = 32;
    localparam int REDUN_BITS  = 1;
    localparam int NUM_WORDS   = 32;
    localparam int I_WORD      = NUM_WORDS + 1;
    localparam int COEF_BITS   = WORD_BITS + REDUN_BITS;
    localparam int POLY_BITS   = I_WORD * COEF_BITS;
    localparam int ITER_BITS   = 64;
    localparam int TIMEOUT_CYC = 1024;

    typedef logic [COEF_BITS-1:0] coef_t;
    typedef coef_t [I_WORD-1:0]   poly_t;
    typedef logic [ITER_BITS-1:0] iter_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } seq_state_t;

endpackage

// File: rtl/vdf_watchdog.sv
// Cycle counter that flags a squarer result as overdue.
// Clear has priority over enable; expire is asserted in the TIMEOUT_CYC-th enabled cycle.
module vdf_watchdog #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire = i_en && (r_cnt == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/vdf_sq_sequencer.sv
// Iteration controller: runs T dependent squarings on a seed and
// returns x^(2^T) in redundant polynomial form.
module vdf_sq_sequencer
    import poly_mod_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_rst,
    input  logic  i_val,
    output logic  o_rdy,
    input  poly_t i_dat,
    input  iter_t i_iters,
    input  logic  i_abort,
    output logic  o_sq_val,
    output poly_t o_sq_dat,
    input  logic  i_sq_val,
    input  poly_t i_sq_dat,
    output logic  o_val,
    output poly_t o_dat,
    output logic  o_err,
    output iter_t o_iter
);

    seq_state_t r_state;
    seq_state_t w_nxt;
    poly_t      r_loop;
    poly_t      r_dat;
    iter_t      r_iters;
    iter_t      r_iter;
    logic       r_val;
    logic       r_err;
    logic       r_to;
    logic       r_drain;

    logic w_acc;
    logic w_res;
    logic w_to;
    logic w_fin;
    logic w_drain_set;
    logic w_drain_clr;
    logic w_wd_en;
    logic w_wd_clr;
    logic w_expire;

    assign o_rdy    = (r_state == IDLE) && !r_drain;
    assign o_sq_val = (r_state == ISSUE);
    assign o_sq_dat = r_loop;
    assign o_val    = r_val;
    assign o_dat    = r_dat;
    assign o_err    = r_err;
    assign o_iter   = r_iter;

    // The watchdog also covers a stale op still owed to us after an abort.
    assign w_wd_en  = (r_state == WAIT) || r_drain;
    assign w_wd_clr = i_sq_val || !w_wd_en || w_drain_set;

    vdf_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wd (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (w_wd_clr),
        .i_en     (w_wd_en),
        .o_expire (w_expire)
    );

    always_comb begin
        w_nxt       = r_state;
        w_acc       = 1'b0;
        w_res       = 1'b0;
        w_to        = 1'b0;
        w_fin       = 1'b0;
        w_drain_set = 1'b0;
        w_drain_clr = r_drain && (i_sq_val || w_expire);
        unique case (r_state)
            IDLE: begin
                if (i_val && o_rdy) begin
                    w_acc = 1'b1;
                    w_nxt = (i_iters == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (i_abort) begin
                    w_nxt       = IDLE;
                    w_drain_set = 1'b1;
                end else begin
                    w_nxt = WAIT;
                end
            end
            WAIT: begin
                if (i_abort) begin
                    w_nxt       = IDLE;
                    w_drain_set = !i_sq_val;
                end else if (i_sq_val) begin
                    w_res = 1'b1;
                    w_nxt = (r_iter + ITER_BITS'(1) == r_iters) ? DONE : ISSUE;
                end else if (w_expire) begin
                    w_to  = 1'b1;
                    w_nxt = DONE;
                end
            end
            DONE: begin
                w_fin = !i_abort;
                w_nxt = IDLE;
            end
            default: w_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_loop  <= '0;
            r_dat   <= '0;
            r_iters <= '0;
            r_iter  <= '0;
            r_val   <= 1'b0;
            r_err   <= 1'b0;
            r_to    <= 1'b0;
            r_drain <= 1'b0;
        end else begin
            r_val <= w_fin;
            r_err <= w_fin && r_to;
            if (w_fin) begin
                r_dat <= r_loop;
            end
            if (w_acc) begin
                r_loop  <= i_dat;
                r_iters <= i_iters;
                r_iter  <= '0;
            end else if (w_res) begin
                r_loop <= i_sq_dat;
                r_iter <= r_iter + ITER_BITS'(1);
            end
            if (w_acc) begin
                r_to <= 1'b0;
            end else if (w_to) begin
                r_to <= 1'b1;
            end
            if (w_drain_set) begin
                r_drain <= 1'b1;
            end else if (w_drain_clr) begin
                r_drain <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vdf_sq_sequencer.sv
// Bench for vdf_sq_sequencer: behavioural squarer (x^2 mod M, random
// latency) plus a big-integer reference for x^(2^T) mod M.
module tb_vdf_sq_sequencer;
    import poly_mod_pkg::*;

    typedef logic [2199:0] big_t;

    logic  clk = 1'b0;
    logic  rst;
    logic  i_val;
    logic  i_abort;
    logic  sq_v;
    poly_t i_dat;
    poly_t sq_d;
    iter_t i_iters;
    logic  o_rdy;
    logic  o_sq_val;
    logic  o_val;
    logic  o_err;
    poly_t o_sq_dat;
    poly_t o_dat;
    iter_t o_iter;

    always #5 clk = ~clk;

    vdf_sq_sequencer dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_val    (i_val),
        .o_rdy    (o_rdy),
        .i_dat    (i_dat),
        .i_iters  (i_iters),
        .i_abort  (i_abort),
        .o_sq_val (o_sq_val),
        .o_sq_dat (o_sq_dat),
        .i_sq_val (sq_v),
        .i_sq_dat (sq_d),
        .o_val    (o_val),
        .o_dat    (o_dat),
        .o_err    (o_err),
        .o_iter   (o_iter)
    );

    int    total = 0;
    int    bad = 0;
    int    n_sq = 0;
    int    n_resp = 0;
    int    n_val = 0;
    int    rsp_lat;
    bit    mute = 1'b0;
    poly_t last_op;
    big_t  M;

    poly_t cap_dat;
    logic  cap_err;
    iter_t cap_iter;

    function automatic big_t p2i(poly_t p);
        big_t v = '0;
        for (int i = I_WORD - 1; i >= 0; i--) v = (v << WORD_BITS) + big_t'(p[i]);
        return v;
    endfunction

    function automatic poly_t i2p(big_t v);
        poly_t p = '0;
        for (int i = 0; i < NUM_WORDS; i++) p[i] = coef_t'(v[i*WORD_BITS +: WORD_BITS]);
        return p;
    endfunction

    function automatic big_t sqm(big_t v);
        return (v * v) % M;
    endfunction

    function automatic big_t ref_pow(big_t x, int t);
        big_t r = x;
        for (int i = 0; i < t; i++) r = sqm(r);
        return r % M;
    endfunction

    function automatic poly_t rnd_poly();
        poly_t p = '0;
        for (int i = 0; i < NUM_WORDS; i++) p[i] = coef_t'($urandom());
        return p;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input big_t obs, input big_t exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got ..%0h want ..%0h", tag, obs[255:0], exp[255:0]);
        end
    endtask

    // Squarer model: one op at a time, result after 5..40 cycles.
    initial begin
        sq_v = 1'b0;
        sq_d = '0;
        forever begin
            if (o_sq_val === 1'b1) begin
                n_sq++;
                last_op = o_sq_dat;
                rsp_lat = $urandom_range(40, 5);
                repeat (rsp_lat - 1) @(negedge clk);
                if (!mute) begin
                    sq_d = i2p(sqm(p2i(last_op)));
                    sq_v = 1'b1;
                    n_resp++;
                    @(negedge clk);
                    sq_v = 1'b0;
                end
            end else begin
                @(negedge clk);
            end
        end
    end

    always @(negedge clk) if (o_val === 1'b1) n_val++;

    task automatic start(input poly_t x, input iter_t t);
        i_dat   = x;
        i_iters = t;
        i_val   = 1'b1;
        @(negedge clk);
        i_val = 1'b0;
    endtask

    task automatic wait_done(input int lim, output int lat);
        bit got = 1'b0;
        lat = 0;
        while (lat < lim) begin
            if (o_val === 1'b1) begin
                got      = 1'b1;
                cap_dat  = o_dat;
                cap_err  = o_err;
                cap_iter = o_iter;
                break;
            end
            @(negedge clk);
            lat++;
        end
        chk("done_seen", 64'(got), 64'd1);
    endtask

    task automatic run_job(input string tag, input poly_t x, input int t);
        int    s0 = n_sq;
        int    lat;
        big_t  exp_v;
        exp_v = ref_pow(p2i(x), t);
        start(x, iter_t'(t));
        wait_done(3000, lat);
        chk_b({tag, "_dat"}, p2i(cap_dat) % M, exp_v);
        chk({tag, "_iter"}, cap_iter, 64'(t));
        chk({tag, "_nsq"}, 64'(n_sq - s0), 64'(t));
        chk({tag, "_err"}, 64'(cap_err), 64'd0);
    endtask

    initial begin
        int    lat;
        int    s0;
        int    r0;
        int    v0;
        int    k;
        poly_t x;
        M       = (big_t'(1) << 1024) - big_t'(189);
        rst     = 1'b1;
        i_val   = 1'b0;
        i_abort = 1'b0;
        i_dat   = '0;
        i_iters = '0;
        repeat (3) @(negedge clk);
        chk("rst_rdy", 64'(o_rdy), 64'd1);
        chk("rst_sqval", 64'(o_sq_val), 64'd0);
        chk("rst_val", 64'(o_val), 64'd0);
        chk("rst_err", 64'(o_err), 64'd0);
        chk("rst_iter", o_iter, 64'd0);
        chk_b("rst_dat", p2i(o_dat), big_t'(0));
        chk_b("rst_sqdat", p2i(o_sq_dat), big_t'(0));
        rst = 1'b0;
        @(negedge clk);

        // T=0: no squarings, seed returned untouched
        s0 = n_sq;
        start(i2p(2), '0);
        wait_done(50, lat);
        chk("t0_lat", 64'(lat), 64'd1);
        chk_b("t0_dat", p2i(cap_dat), big_t'(2));
        chk("t0_iter", cap_iter, 64'd0);
        chk("t0_nsq", 64'(n_sq - s0), 64'd0);
        chk("t0_rdy", 64'(o_rdy), 64'd1);

        // T=1
        s0 = n_sq;
        start(i2p(2), 64'd1);
        wait_done(200, lat);
        chk("t1_nsq", 64'(n_sq - s0), 64'd1);
        chk_b("t1_op", p2i(last_op), big_t'(2));
        chk_b("t1_dat", p2i(cap_dat) % M, big_t'(4));
        chk("t1_iter", cap_iter, 64'd1);

        run_job("t20", i2p(2), 20);

        // Abort with the 8th squaring in flight
        x  = rnd_poly();
        s0 = n_sq;
        start(x, 64'd100);
        k = 0;
        while (n_sq < s0 + 8 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("ab_reach", 64'(n_sq - s0), 64'd8);
        @(negedge clk);
        chk("ab_iter_pre", o_iter, 64'd7);
        v0      = n_val;
        r0      = n_resp;
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        chk("ab_rdy_low", 64'(o_rdy), 64'd0);
        k = 0;
        while (o_rdy !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("ab_rdy_back", 64'(o_rdy), 64'd1);
        chk("ab_stale_first", 64'(n_resp - r0), 64'd1);
        chk("ab_no_val", 64'(n_val - v0), 64'd0);
        chk("ab_iter", o_iter, 64'd7);
        run_job("ab_next", i2p(3), 1);
        chk_b("ab_next9", p2i(cap_dat) % M, big_t'(9));

        // Squarer silent: watchdog ends the job with the seed
        mute = 1'b1;
        x    = rnd_poly();
        s0   = n_sq;
        start(x, 64'd5);
        wait_done(TIMEOUT_CYC + 50, lat);
        chk("to_lat", 64'(lat), 64'(TIMEOUT_CYC + 2));
        chk("to_err", 64'(cap_err), 64'd1);
        chk_b("to_dat", p2i(cap_dat), p2i(x));
        chk("to_iter", cap_iter, 64'd0);
        chk("to_nsq", 64'(n_sq - s0), 64'd1);
        mute = 1'b0;
        @(negedge clk);
        chk("to_err_pulse", 64'(o_err), 64'd0);

        // i_val while busy is dropped
        x  = rnd_poly();
        s0 = n_sq;
        start(x, 64'd10);
        repeat (30) @(negedge clk);
        chk("busy_rdy", 64'(o_rdy), 64'd0);
        i_dat   = i2p(7);
        i_iters = 64'd3;
        i_val   = 1'b1;
        @(negedge clk);
        i_val = 1'b0;
        wait_done(3000, lat);
        chk_b("busy_dat", p2i(cap_dat) % M, ref_pow(p2i(x), 10));
        chk("busy_iter", cap_iter, 64'd10);
        chk("busy_nsq", 64'(n_sq - s0), 64'd10);
        run_job("after_busy", rnd_poly(), 2);

        for (int j = 0; j < 6; j++) begin
            run_job("rnd", rnd_poly(), $urandom_range(5, 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
